// File: rtl/stream_deserializer.sv
// stream_deserializer: packs RATIO narrow beats into one wide word, with early close on in_last_i
module stream_deserializer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [WIDTH-1:0]         in_data_i,
    input  logic                     in_last_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [WIDTH*RATIO-1:0]   out_data_o,
    output logic [RATIO-1:0]         out_mask_o,
    output logic                     out_last_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i
);
    localparam int CW = $clog2(RATIO);
    localparam logic [CW-1:0] LAST_SLOT = CW'(RATIO - 1);

    typedef enum logic {FILL, HOLD} state_e;

    state_e                   state_q;
    logic [CW-1:0]            cnt_q;
    logic [WIDTH*RATIO-1:0]   data_q, data_d;
    logic [RATIO-1:0]         mask_q, mask_d;
    logic                     last_q, last_d;
    logic                     in_fire, out_fire, close;
    logic [CW-1:0]            slot;

    // Held word is released at the same edge a new beat arrives, so HOLD can accept when downstream takes the word
    assign in_ready_o  = rst_ni & ((state_q == FILL) | out_ready_i);
    assign out_valid_o = rst_ni & (state_q == HOLD);
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i;
    assign out_data_o  = data_q;
    assign out_mask_o  = mask_q;
    assign out_last_o  = last_q;

    // A beat arriving on the output handshake starts a fresh word at slot 0
    assign slot  = out_fire ? '0 : cnt_q;
    assign close = in_last_i | (slot == LAST_SLOT);

    // Next word contents: clear on output handshake, then merge the incoming beat
    always_comb begin
        data_d = out_fire ? '0 : data_q;
        mask_d = out_fire ? '0 : mask_q;
        last_d = out_fire ? 1'b0 : last_q;
        if (in_fire) begin
            for (int k = 0; k < RATIO; k++)
                if (slot == CW'(k)) data_d[k*WIDTH +: WIDTH] = in_data_i;
            mask_d[slot] = 1'b1;
            last_d       = in_last_i;
        end
    end

    // FILL/HOLD control, beat counter and word register; reset beats any handshake
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            mask_q  <= mask_d;
            last_q  <= last_d;
            state_q <= in_fire ? (close ? HOLD : FILL) : (out_fire ? FILL : state_q);
            cnt_q   <= in_fire ? (close ? '0 : slot + CW'(1)) : (out_fire ? '0 : cnt_q);
        end
    end
endmodule
